// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver and four-key make/break decoder.
// Produces held-key levels plus the last good byte for debug.
module ps2_key_decoder #(
    parameter logic [7:0] KEY0_CODE      = 8'h1D,
    parameter bit         KEY0_EXT       = 1'b0,
    parameter logic [7:0] KEY1_CODE      = 8'h1B,
    parameter bit         KEY1_EXT       = 1'b0,
    parameter logic [7:0] KEY2_CODE      = 8'h75,
    parameter bit         KEY2_EXT       = 1'b1,
    parameter logic [7:0] KEY3_CODE      = 8'h5A,
    parameter bit         KEY3_EXT       = 1'b0,
    parameter int         FILTER_LEN     = 8,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [3:0] key_pressed,
    output logic [7:0] scan_code,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [31:0] KEY_CODES = {KEY3_CODE, KEY2_CODE, KEY1_CODE, KEY0_CODE};
    localparam logic [3:0]  KEY_EXTS  = {KEY3_EXT, KEY2_EXT, KEY1_EXT, KEY0_EXT};

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } rx_state_t;

    logic          clk_s1, clk_s2;
    logic          dat_s1, dat_s2;
    logic [FW-1:0] filt_cnt;
    logic          filt_clk, filt_clk_d;
    logic          strobe;

    rx_state_t     state;
    logic [7:0]    shreg;
    logic [2:0]    bit_cnt;
    logic          par_bit;
    logic [TW-1:0] to_cnt;

    logic          ext_flag, brk_flag;

    // Both lines idle high, so the synchronisers reset to 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    // Filtered clock only follows a level held for FILTER_LEN consecutive cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_cnt   <= '0;
            filt_clk   <= 1'b1;
            filt_clk_d <= 1'b1;
        end else begin
            filt_clk_d <= filt_clk;
            if (clk_s2 != filt_clk) begin
                if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                    filt_clk <= clk_s2;
                    filt_cnt <= '0;
                end else begin
                    filt_cnt <= filt_cnt + 1'b1;
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    assign strobe = filt_clk_d & ~filt_clk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            par_bit    <= 1'b0;
            to_cnt     <= '0;
            scan_code  <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;

            if (state == S_IDLE || strobe) begin
                to_cnt <= '0;
            end else if (to_cnt != TW'(TIMEOUT_CYCLES)) begin
                to_cnt <= to_cnt + 1'b1;
            end

            if (state != S_IDLE && !strobe && to_cnt == TW'(TIMEOUT_CYCLES)) begin
                // Stalled mid-frame: drop the partial byte, keep prefix flags.
                state     <= S_IDLE;
                frame_err <= 1'b1;
                to_cnt    <= '0;
            end else if (strobe) begin
                case (state)
                    S_IDLE: begin
                        if (!dat_s2) begin
                            state   <= S_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    S_DATA: begin
                        shreg   <= {dat_s2, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            state <= S_PARITY;
                        end
                    end
                    S_PARITY: begin
                        par_bit <= dat_s2;
                        state   <= S_STOP;
                    end
                    S_STOP: begin
                        if (dat_s2 && (^{shreg, par_bit})) begin
                            scan_code  <= shreg;
                            byte_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // E0/F0 prefixes accumulate until the next non-prefix byte consumes them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_pressed <= '0;
            ext_flag    <= 1'b0;
            brk_flag    <= 1'b0;
        end else if (byte_valid) begin
            if (scan_code == 8'hE0) begin
                ext_flag <= 1'b1;
            end else if (scan_code == 8'hF0) begin
                brk_flag <= 1'b1;
            end else begin
                for (int n = 0; n < 4; n++) begin
                    if (scan_code == KEY_CODES[n*8 +: 8] && ext_flag == KEY_EXTS[n]) begin
                        key_pressed[n] <= ~brk_flag;
                    end
                end
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
            end
        end
    end

endmodule
